add_round_key_stream: RTL and testbench

// Parametrised AddRoundKey stage with an on-chip round-key store and valid/ready streaming.

---
 rtl/add_round_key_stream.sv | 153 +++++++++++++++
 tb/tb_add_round_key_stream.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stream.sv
// add_round_key_stream
//
// AddRoundKey stage for the AES core. It holds the expanded round keys and
// streams state blocks through with a valid/ready handshake. Each accepted
// block is XORed with the key selected by its round index. In decrypt mode the
// key order is reversed. A 2-entry output buffer keeps full throughput when
// downstream applies back-pressure.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   key_wr_en    write key_wr_data into slot key_wr_idx (ignored if idx >= NUM_KEYS)
//   key_wr_idx   key slot to write
//   key_wr_data  round key value
//   key_clear    invalidate all key slots; wins over key_wr_en
//   dec_mode     0: key = slot[in_round], 1: key = slot[NUM_KEYS-1-in_round]
//   in_valid     input block valid
//   in_ready     stage can accept a block (registered state only)
//   in_data      state block
//   in_round     round index of the block
//   out_valid    output block valid
//   out_ready    downstream accepts the output block
//   out_data     in_data ^ selected key (in_data unchanged on error)
//   out_round    in_round carried with the block
//   out_err      block used an invalid or out-of-range key
//   keys_loaded  every key slot holds a valid key
module add_round_key_stream #(
  parameter int DATA_LEN = 128,
  parameter int NUM_KEYS = 11,
  localparam int IDX_W = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_wr_en,
  input  logic [IDX_W-1:0]    key_wr_idx,
  input  logic [DATA_LEN-1:0] key_wr_data,
  input  logic                key_clear,
  input  logic                dec_mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic [IDX_W-1:0]    in_round,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic [IDX_W-1:0]    out_round,
  output logic                out_err,
  output logic                keys_loaded
);

  // One extra bit so the compare also works when NUM_KEYS is a power of two.
  localparam logic [IDX_W:0]   NUM_KEYS_EXT = (IDX_W + 1)'(NUM_KEYS);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_KEYS - 1);

  logic [DATA_LEN-1:0] key_mem [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_valid;

  logic [DATA_LEN-1:0] buf_data  [2];
  logic [IDX_W-1:0]    buf_round [2];
  logic [1:0]          buf_err;
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;

  logic                push;
  logic                pop;
  logic                in_range;
  logic [IDX_W-1:0]    eff_idx;
  logic [DATA_LEN-1:0] sel_key;
  logic                sel_hit;
  logic                sel_err;
  logic [DATA_LEN-1:0] blk_data;

  assign in_ready    = (count != 2'd2);
  assign out_valid   = (count != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign keys_loaded = &key_valid;

  // Key selection uses the key store as it was before this edge, so a block
  // accepted together with a write to its own slot still sees the old key.
  // eff_idx may alias a real slot when in_round is out of range; in_range
  // forces the error path in that case.
  always_comb begin
    in_range = ({1'b0, in_round} < NUM_KEYS_EXT);
    eff_idx  = dec_mode ? (LAST_IDX - in_round) : in_round;
    sel_key  = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (eff_idx == IDX_W'(k)) begin
        sel_key = key_mem[k];
        sel_hit = key_valid[k];
      end
    end
    sel_err  = !(in_range && sel_hit);
    blk_data = sel_err ? in_data : (in_data ^ sel_key);
  end

  // Key store: clear invalidates slots but leaves key data in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        key_mem[k] <= '0;
      end
    end else if (key_clear) begin
      key_valid <= '0;
    end else if (key_wr_en) begin
      // Only indices that match a real slot are written; larger ones drop out.
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_wr_idx == IDX_W'(k)) begin
          key_mem[k]   <= key_wr_data;
          key_valid[k] <= 1'b1;
        end
      end
    end
  end

  // Output buffer: 2-entry ring; the head entry drives the outputs directly,
  // so a push into an empty buffer is visible right after the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      buf_err <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        buf_data[i]  <= '0;
        buf_round[i] <= '0;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr]  <= blk_data;
        buf_round[wr_ptr] <= in_round;
        buf_err[wr_ptr]   <= sel_err;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_data  = buf_data[rd_ptr];
  assign out_round = buf_round[rd_ptr];
  assign out_err   = buf_err[rd_ptr];

endmodule

// File: tb/tb_add_round_key_stream.sv
// Testbench for add_round_key_stream: vector table, hand-written corner-case
// sequences and a randomized run checked against a queue-based model.
module tb_add_round_key_stream;

  localparam int DATA_LEN = 128;
  localparam int NUM_KEYS = 11;
  localparam int IDX_W    = $clog2(NUM_KEYS);

  logic                clk;
  logic                reset;
  logic                key_wr_en;
  logic [IDX_W-1:0]    key_wr_idx;
  logic [DATA_LEN-1:0] key_wr_data;
  logic                key_clear;
  logic                dec_mode;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_data;
  logic [IDX_W-1:0]    in_round;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic [IDX_W-1:0]    out_round;
  logic                out_err;
  logic                keys_loaded;

  add_round_key_stream #(.DATA_LEN(DATA_LEN), .NUM_KEYS(NUM_KEYS)) dut (
    .clk(clk), .reset(reset),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_clear(key_clear), .dec_mode(dec_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_round(out_round), .out_err(out_err), .keys_loaded(keys_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_d(input string name, input logic [DATA_LEN-1:0] act,
                         input logic [DATA_LEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_r(input string name, input logic [IDX_W-1:0] act,
                         input logic [IDX_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DATA_LEN-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [DATA_LEN-1:0] d;
    logic [IDX_W-1:0]    r;
    logic                e;
  } exp_t;

  exp_t                q[$];
  logic [DATA_LEN-1:0] mkey   [NUM_KEYS];
  bit                  mvalid [NUM_KEYS];

  always begin
    exp_t e;
    bit   acc;
    bit   pp;
    bit   all_valid;
    int   rr;
    int   eff;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      for (int k = 0; k < NUM_KEYS; k++) begin
        mkey[k]   = '0;
        mvalid[k] = 1'b0;
      end
    end else begin
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      if (acc) begin
        rr  = int'(in_round);
        eff = dec_mode ? (NUM_KEYS - 1 - rr) : rr;
        e.r = in_round;
        if (rr >= NUM_KEYS || !mvalid[eff]) begin
          e.e = 1'b1;
          e.d = in_data;
        end else begin
          e.e = 1'b0;
          e.d = in_data ^ mkey[eff];
        end
      end
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (key_clear) begin
        for (int k = 0; k < NUM_KEYS; k++) mvalid[k] = 1'b0;
      end else if (key_wr_en && int'(key_wr_idx) < NUM_KEYS) begin
        mkey[int'(key_wr_idx)]   = key_wr_data;
        mvalid[int'(key_wr_idx)] = 1'b1;
      end
    end
    all_valid = 1'b1;
    for (int k = 0; k < NUM_KEYS; k++) if (!mvalid[k]) all_valid = 1'b0;
    check_b("sb_out_valid", out_valid, q.size() > 0);
    check_b("sb_in_ready", in_ready, q.size() < 2);
    check_b("sb_keys_loaded", keys_loaded, all_valid);
    if (q.size() > 0) begin
      check_d("sb_out_data", out_data, q[0].d);
      check_r("sb_out_round", out_round, q[0].r);
      check_b("sb_out_err", out_err, q[0].e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    key_wr_en = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic write_key(input int idx, input logic [DATA_LEN-1:0] k);
    @(negedge clk);
    key_wr_en   = 1'b1;
    key_wr_idx  = IDX_W'(idx);
    key_wr_data = k;
    @(negedge clk);
    key_wr_en   = 1'b0;
  endtask

  // Leaves in_valid high after the accepting edge; the caller drops it.
  task automatic send_block(input logic d, input logic [IDX_W-1:0] r,
                            input logic [DATA_LEN-1:0] x);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    dec_mode = d;
    in_round = r;
    in_data  = x;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_b("send_timeout_in_ready", in_ready, 1'b1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic                dec;
    logic [IDX_W-1:0]    rnd;
    logic [DATA_LEN-1:0] din;
    logic [DATA_LEN-1:0] dout;
    logic                err;
  } vec_t;

  vec_t                tbl [9];
  logic [DATA_LEN-1:0] xa, xb, xc, newk;
  logic [IDX_W-1:0]    got [8];
  int                  n_got;
  bit                  acc;
  bit                  rdy;

  initial begin
    // slot k holds {16{8'hk}} once loaded
    tbl[0] = '{1'b0, 4'd0,  128'h0123456789abcdeffedcba9876543210,
               128'h0123456789abcdeffedcba9876543210, 1'b0};
    tbl[1] = '{1'b0, 4'd5,  128'h0, {16{8'h05}}, 1'b0};
    tbl[2] = '{1'b1, 4'd0,  128'h0, {16{8'h0a}}, 1'b0};
    tbl[3] = '{1'b1, 4'd10, {16{8'hff}}, {16{8'hff}}, 1'b0};
    tbl[4] = '{1'b1, 4'd3,  128'h0, {16{8'h07}}, 1'b0};
    tbl[5] = '{1'b0, 4'd10, {16{8'hff}}, {16{8'hf5}}, 1'b0};
    tbl[6] = '{1'b0, 4'd12, 128'h1234, 128'h1234, 1'b1};
    tbl[7] = '{1'b1, 4'd11, 128'h55, 128'h55, 1'b1};
    tbl[8] = '{1'b0, 4'd15, {16{8'ha5}}, {16{8'ha5}}, 1'b1};

    reset       = 1'b1;
    key_wr_en   = 1'b0;
    key_wr_idx  = '0;
    key_wr_data = '0;
    key_clear   = 1'b0;
    dec_mode    = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_round    = '0;
    out_ready   = 1'b1;

    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_b("rst_out_valid", out_valid, 1'b0);
    check_d("rst_out_data", out_data, '0);
    check_r("rst_out_round", out_round, '0);
    check_b("rst_out_err", out_err, 1'b0);
    check_b("rst_keys_loaded", keys_loaded, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_b("rst_in_ready", in_ready, 1'b1);

    // no keys loaded: block passes through with error
    xa = rand_data();
    send_block(1'b0, 4'd3, xa);
    check_d("nokey_out_data", out_data, xa);
    check_b("nokey_out_err", out_err, 1'b1);
    idle();

    // load all keys
    for (int k = 0; k < NUM_KEYS; k++) write_key(k, {16{8'(k)}});
    check_b("load_keys_loaded", keys_loaded, 1'b1);

    // stream rounds 0..10 back to back
    out_ready = 1'b1;
    for (int k = 0; k < NUM_KEYS; k++) begin
      @(negedge clk);
      xa       = rand_data();
      in_valid = 1'b1;
      dec_mode = 1'b0;
      in_round = IDX_W'(k);
      in_data  = xa;
      check_b("stream_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      check_b("stream_out_valid", out_valid, 1'b1);
      check_r("stream_out_round", out_round, IDX_W'(k));
      check_d("stream_out_data", out_data, xa ^ {16{8'(k)}});
      check_b("stream_out_err", out_err, 1'b0);
    end
    idle();

    // vector table
    for (int i = 0; i < 9; i++) begin
      send_block(tbl[i].dec, tbl[i].rnd, tbl[i].din);
      check_b("tbl_out_valid", out_valid, 1'b1);
      check_d("tbl_out_data", out_data, tbl[i].dout);
      check_r("tbl_out_round", out_round, tbl[i].rnd);
      check_b("tbl_out_err", out_err, tbl[i].err);
      idle();
    end

    // back-pressure: 3 blocks offered, 2 accepted, outputs held
    @(negedge clk);
    out_ready = 1'b0;
    xa = rand_data();
    xb = rand_data();
    xc = rand_data();
    send_block(1'b0, 4'd1, xa);
    send_block(1'b0, 4'd2, xb);
    @(negedge clk);
    in_round = 4'd3;
    in_data  = xc;
    for (int c = 0; c < 3; c++) begin
      check_b("bp_in_ready", in_ready, 1'b0);
      check_b("bp_out_valid", out_valid, 1'b1);
      check_d("bp_out_data", out_data, xa ^ {16{8'h01}});
      check_r("bp_out_round", out_round, 4'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid && n_got < 8) begin
        got[n_got] = out_round;
        n_got++;
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    check_d("bp_drain_count", DATA_LEN'(n_got), DATA_LEN'(3));
    if (n_got >= 3) begin
      check_r("bp_order0", got[0], 4'd1);
      check_r("bp_order1", got[1], 4'd2);
      check_r("bp_order2", got[2], 4'd3);
    end

    // key write on the same edge as a block using that slot
    newk = rand_data();
    xa = rand_data();
    xb = rand_data();
    @(negedge clk);
    key_wr_en   = 1'b1;
    key_wr_idx  = 4'd2;
    key_wr_data = newk;
    in_valid    = 1'b1;
    dec_mode    = 1'b0;
    in_round    = 4'd2;
    in_data     = xa;
    @(posedge clk);
    #1;
    check_d("samewr_old_key", out_data, xa ^ {16{8'h02}});
    @(negedge clk);
    key_wr_en = 1'b0;
    in_data   = xb;
    @(posedge clk);
    #1;
    check_d("samewr_new_key", out_data, xb ^ newk);
    check_b("samewr_err", out_err, 1'b0);
    @(negedge clk);
    in_valid    = 1'b0;
    key_clear   = 1'b1;
    key_wr_en   = 1'b1;
    key_wr_idx  = 4'd5;
    key_wr_data = rand_data();
    @(posedge clk);
    #1;
    check_b("clear_keys_loaded", keys_loaded, 1'b0);
    idle();
    xa = rand_data();
    send_block(1'b0, 4'd5, xa);
    check_b("clear_slot_err", out_err, 1'b1);
    check_d("clear_slot_data", out_data, xa);
    idle();

    // randomized traffic
    for (int k = 0; k < NUM_KEYS; k++) write_key(k, rand_data());
    rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!(in_valid && !rdy)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        dec_mode = 1'($urandom_range(0, 1));
        in_round = IDX_W'($urandom_range(0, 15));
        in_data  = rand_data();
      end
      out_ready   = ($urandom_range(0, 2) != 0);
      key_wr_en   = ($urandom_range(0, 3) == 0);
      key_wr_idx  = IDX_W'($urandom_range(0, 15));
      key_wr_data = rand_data();
      key_clear   = ($urandom_range(0, 63) == 0);
      rdy = in_ready;
    end
    idle();

    // reset with two blocks buffered
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NUM_KEYS; k++) write_key(k, {16{8'(k)}});
    @(negedge clk);
    out_ready = 1'b0;
    send_block(1'b0, 4'd4, rand_data());
    send_block(1'b0, 4'd6, rand_data());
    @(negedge clk);
    in_valid = 1'b0;
    check_b("mid_full_in_ready", in_ready, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_b("mid_rst_out_valid", out_valid, 1'b0);
    check_b("mid_rst_in_ready", in_ready, 1'b1);
    check_b("mid_rst_keys_loaded", keys_loaded, 1'b0);
    check_d("mid_rst_out_data", out_data, '0);
    check_b("mid_rst_out_err", out_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_b("post_rst_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
